// File: rtl/imem_boot_loader_if.sv
// Byte-stream channel into the instruction-memory boot loader.
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready are both 1;
// the source holds in_data stable while in_valid=1 and in_ready=0, and may drop
// in_valid between bytes at any time.
interface imem_boot_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image (16-bit word count, little-endian
// payload words, XOR checksum), writes it into instruction memory from word 0 and
// releases the core from reset only once the whole image has been verified.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    imem_boot_loader_if.slave     s_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [2:0]            state_dbg
);
    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [15:0]           DEPTH16  = 16'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic        live;       // 0 during reset and the first cycle after it; gates in_ready
    logic [7:0]  cnt_lo;     // CNT_LO held until CNT_HI arrives
    logic [15:0] n_words;    // word count of the current frame
    logic [7:0]  acc;        // running XOR of header and payload bytes
    logic [1:0]  byte_idx;   // byte position within the current payload word
    logic [23:0] shreg;      // bytes b2,b1,b0 of the word being assembled
    logic        loading;
    logic        xfer;
    logic        word_done;
    logic        last_word;
    logic        rearm;
    logic [15:0] n_hdr;

    assign loading   = (state == S_HDR0) || (state == S_HDR1) ||
                       (state == S_DATA) || (state == S_CHECK);
    assign s_in.in_ready = live && loading;
    assign xfer      = s_in.in_valid && s_in.in_ready;
    assign word_done = (state == S_DATA) && xfer && (byte_idx == 2'd3);
    // words_loaded already counts every earlier word when a 4th byte arrives,
    // because a write retires three cycles before the next word can complete.
    assign last_word = (16'(words_loaded) + 16'd1) == n_words;
    assign rearm     = start && ((state == S_DONE) || (state == S_ERROR));
    assign n_hdr     = {s_in.in_data, cnt_lo};

    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign core_rst_n = (state == S_DONE);
    assign state_dbg  = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HDR0;
        else      state <= state_nx;
    end

    // Next-state decode driven by accepted bytes and the re-arm pulse.
    always_comb begin
        state_nx = state;
        case (state)
            S_HDR0:  if (xfer) state_nx = S_HDR1;
            S_HDR1: begin
                if (xfer) begin
                    if (n_hdr > DEPTH16)     state_nx = S_ERROR;
                    else if (n_hdr == 16'd0) state_nx = S_CHECK;
                    else                     state_nx = S_DATA;
                end
            end
            S_DATA:  if (word_done && last_word) state_nx = S_CHECK;
            S_CHECK: if (xfer) state_nx = (s_in.in_data == acc) ? S_DONE : S_ERROR;
            S_DONE:  if (start) state_nx = S_HDR0;
            S_ERROR: if (start) state_nx = S_HDR0;
            default: state_nx = S_HDR0;
        endcase
    end

    // Datapath: header capture, checksum, word assembly and registered memory write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live         <= 1'b0;
            cnt_lo       <= '0;
            n_words      <= '0;
            acc          <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            live   <= 1'b1;
            mem_we <= word_done;
            if (word_done) mem_wdata <= {s_in.in_data, shreg};
            // Advance after the write cycle; the address stops at the last word.
            if (mem_we) begin
                words_loaded <= words_loaded + 1'b1;
                if (mem_addr != ADDR_MAX) mem_addr <= mem_addr + 1'b1;
            end
            if (rearm) begin
                acc          <= '0;
                byte_idx     <= '0;
                words_loaded <= '0;
                mem_addr     <= '0;
            end else if (xfer) begin
                case (state)
                    S_HDR0: begin
                        cnt_lo <= s_in.in_data;
                        acc    <= acc ^ s_in.in_data;
                    end
                    S_HDR1: begin
                        n_words <= n_hdr;
                        acc     <= acc ^ s_in.in_data;
                    end
                    S_DATA: begin
                        acc      <= acc ^ s_in.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        shreg    <= {s_in.in_data, shreg[23:8]};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames plus randomized frames, each scored
// against a frame-level model of the image format.
module tb_imem_boot_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int W     = AW + 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;
    logic [2:0]    state_dbg;

    imem_boot_loader_if s_if ();

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_in         (s_if),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .state_dbg    (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int           vectors    = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [7:0]   frame_q[$];
    logic         exp_done;
    logic         exp_error;
    int           exp_words;

    // Write monitor: every cycle with mem_we high records one write.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: parse the frame and derive writes and final outcome.
    task automatic build_expect();
        int         n;
        logic [7:0] x;
        logic [31:0] word;
        exp_q.delete();
        n = int'({frame_q[1], frame_q[0]});
        if (n > DEPTH) begin
            exp_done = 1'b0; exp_error = 1'b1; exp_words = 0;
            return;
        end
        x = frame_q[0] ^ frame_q[1];
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++) begin
                word = word | (32'(frame_q[2 + 4*w + b]) << (8*b));
                x = x ^ frame_q[2 + 4*w + b];
            end
            exp_q.push_back({AW'(w), word});
        end
        exp_done  = (frame_q[2 + 4*n] == x);
        exp_error = !exp_done;
        exp_words = n;
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n > DEPTH) return;
        x = frame_q[0] ^ frame_q[1];
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    // Driver: present one byte, wait (bounded) for acceptance. Called at a negedge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        s_if.in_data  = b;
        s_if.in_valid = 1'b1;
        while (s_if.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) check("send_timeout", 64'(t), 64'd0);
        @(negedge clk);
        s_if.in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            start = 1'($urandom_range(0, 1));   // must be ignored mid-load
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Send frame_q with optional gaps, then score writes and outcome.
    task automatic run_frame(input int gap_max, input int gap_at);
        int t = 0;
        obs_q.delete();
        build_expect();
        foreach (frame_q[i]) begin
            if (i == gap_at) idle(3);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_byte(frame_q[i]);
        end
        while (!(done === 1'b1 || error === 1'b1) && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("done",         64'(done),         64'(exp_done));
        check("error",        64'(error),        64'(exp_error));
        check("core_rst_n",   64'(core_rst_n),   64'(exp_done));
        check("in_ready_end", 64'(s_if.in_ready), 64'd0);
        check("words_loaded", 64'(words_loaded), 64'(exp_words));
        check("n_writes",     64'(obs_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            check("write", (i < obs_q.size()) ? 64'(obs_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF,
                  64'(exp_q[i]));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rearm_in_ready", 64'(s_if.in_ready), 64'd1);
        check("rearm_done",     64'(done),          64'd0);
        check("rearm_error",    64'(error),         64'd0);
        check("rearm_words",    64'(words_loaded),  64'd0);
        check("rearm_core_rst", 64'(core_rst_n),    64'd0);
    endtask

    task automatic load_scenario2(input logic [7:0] csum);
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00,
                    8'h13, 8'h00, 8'h00, 8'h00, csum};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   64'(s_if.in_ready), 64'd0);
        check({tag, "_mem_we"},     64'(mem_we),        64'd0);
        check({tag, "_mem_addr"},   64'(mem_addr),      64'd0);
        check({tag, "_mem_wdata"},  64'(mem_wdata),     64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n),    64'd0);
        check({tag, "_done"},       64'(done),          64'd0);
        check({tag, "_error"},      64'(error),         64'd0);
        check({tag, "_words"},      64'(words_loaded),  64'd0);
    endtask

    // Directed and randomized steps
    initial begin
        int n;
        rst = 1'b0;
        start = 1'b0;
        s_if.in_data = 8'h00;
        s_if.in_valid = 1'b0;

        // Reset values, in_ready rises one clock after release.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;
        check("ready_at_release", 64'(s_if.in_ready), 64'd0);
        @(negedge clk);
        check("ready_after_clk", 64'(s_if.in_ready), 64'd1);

        // Known two-word image, back-to-back.
        load_scenario2(8'hD0);
        run_frame(0, -1);
        check("w0_const", (obs_q.size() > 0) ? 64'(obs_q[0]) : 64'hFFFF_FFFF_FFFF_FFFF,
              64'({6'd0, 32'h00500293}));
        start_pulse();

        // Bad checksum.
        load_scenario2(8'hD1);
        run_frame(0, -1);
        start_pulse();

        // Empty image, then oversize header.
        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame(0, -1);
        start_pulse();
        frame_q = '{8'h41, 8'h00};
        run_frame(0, -1);
        start_pulse();

        // Exact capacity boundary: N == DEPTH is accepted.
        build_frame(DEPTH, 1'b0);
        run_frame(0, -1);
        start_pulse();

        // Gap of three cycles mid-word.
        load_scenario2(8'hD0);
        run_frame(0, 4);
        start_pulse();

        // Reset after six payload bytes, then a full reload.
        load_scenario2(8'hD0);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i]);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(0, -1);
        start_pulse();

        // Randomized frames with random gaps and corruption.
        for (int it = 0; it < 8; it++) begin
            build_frame($urandom_range(1, 12), ($urandom_range(0, 3) == 0));
            run_frame(2, -1);
            start_pulse();
        end

        // Randomized oversize counts.
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(DEPTH + 1, 65535);
            build_frame(n, 1'b0);
            run_frame(1, -1);
            start_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
